// File: rtl/ccc_mon_pkg.sv
// Shared state encodings and default constants for the CCC lock supervisor.
package ccc_mon_pkg;

  localparam int STATE_W           = 3;
  localparam int STABLE_CYCLES_DEF = 1024;
  localparam int LOSS_FILTER_DEF   = 4;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RUN       = 3'd3,
    ST_FILTER    = 3'd4
  } state_t;

endpackage

// File: rtl/ccc_lock_supervisor_lock_sync.sv
// Multi-flop synchronizer for a single asynchronous level; clears to 0 on reset.
module lock_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic [SYNC_STAGES-1:0] r_sync;

  // shift the async level through the flop chain
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) r_sync <= '0;
    else          r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
  end

  assign o_q = r_sync[SYNC_STAGES-1];

endmodule

// File: rtl/ccc_lock_supervisor.sv
// Fabric-side supervisor for the MSS CCC lock: synchronizes and filters
// FAB_LOCK, gates the fabric reset on qualified lock, and counts losses.
// Optional interrupt output enabled by defining CCC_LOCK_SUPERVISOR_IRQ_EN.
module ccc_lock_supervisor
  import ccc_mon_pkg::*;
#(
  parameter int STABLE_CYCLES = STABLE_CYCLES_DEF,
  parameter int LOSS_FILTER   = LOSS_FILTER_DEF,
  parameter int SYNC_STAGES   = 2,
  parameter int CNT_W         = 8
) (
  input  logic               FAB_CLK,
  input  logic               M2F_RESET_N,
  input  logic               FAB_LOCK,
  input  logic               SW_RESTART,
  input  logic               LOSS_CLR,
`ifdef CCC_LOCK_SUPERVISOR_IRQ_EN
  input  logic               IRQ_CLR,
  output logic               IRQ,
`endif
  output logic               FAB_RESET_N,
  output logic               LOCKED,
  output logic [STATE_W-1:0] STATE,
  output logic [CNT_W-1:0]   LOSS_COUNT
);

  localparam int SC_W = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam int FC_W = $clog2(LOSS_FILTER + 1);
  localparam logic [SC_W-1:0] SC_LAST = SC_W'(STABLE_CYCLES - 1);
  localparam logic [SC_W-1:0] SC_ONE  = SC_W'(1);
  localparam logic [FC_W-1:0] FC_LAST = FC_W'(LOSS_FILTER);
  localparam logic [FC_W-1:0] FC_ONE  = FC_W'(1);

  logic            w_lock_s;
  state_t          r_state, w_nxt;
  logic [SC_W-1:0] r_scnt, w_scnt;
  logic [FC_W-1:0] r_fcnt, w_fcnt;
  logic            w_loss, w_run;
  logic            r_rst_out, r_locked;
  logic [CNT_W-1:0] r_loss_cnt;

  lock_sync #(.SYNC_STAGES(SYNC_STAGES)) u_lock_sync (
    .i_clk   (FAB_CLK),
    .i_rst_n (M2F_RESET_N),
    .i_d     (FAB_LOCK),
    .o_q     (w_lock_s)
  );

  // state and qualification counters
  always_ff @(posedge FAB_CLK) begin
    if (!M2F_RESET_N) begin
      r_state <= ST_IDLE;
      r_scnt  <= '0;
      r_fcnt  <= '0;
    end else begin
      r_state <= w_nxt;
      r_scnt  <= w_scnt;
      r_fcnt  <= w_fcnt;
    end
  end

  // next state; a software restart overrides every other transition
  always_comb begin
    w_nxt  = r_state;
    w_scnt = r_scnt;
    w_fcnt = r_fcnt;
    w_loss = 1'b0;
    if (SW_RESTART && (r_state != ST_IDLE)) begin
      w_nxt  = ST_WAIT_LOCK;
      w_scnt = '0;
      w_fcnt = '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_nxt  = ST_WAIT_LOCK;
          w_scnt = '0;
          w_fcnt = '0;
        end
        ST_WAIT_LOCK: begin
          if (w_lock_s) begin
            w_nxt  = ST_STABLE;
            w_scnt = '0;
          end
        end
        ST_STABLE: begin
          if (!w_lock_s) begin
            w_nxt  = ST_WAIT_LOCK;
            w_scnt = '0;
          end else if (r_scnt == SC_LAST) begin
            w_nxt  = ST_RUN;
          end else begin
            w_scnt = r_scnt + SC_ONE;
          end
        end
        ST_RUN: begin
          if (!w_lock_s) begin
            // a one-sample filter means the first low sample is already a loss
            if (LOSS_FILTER == 1) begin
              w_nxt  = ST_WAIT_LOCK;
              w_loss = 1'b1;
              w_fcnt = '0;
            end else begin
              w_nxt  = ST_FILTER;
              w_fcnt = FC_ONE;
            end
          end
        end
        ST_FILTER: begin
          if (w_lock_s) begin
            w_nxt  = ST_RUN;
            w_fcnt = '0;
          end else if (r_fcnt == FC_LAST) begin
            w_nxt  = ST_WAIT_LOCK;
            w_loss = 1'b1;
            w_fcnt = '0;
          end else begin
            w_fcnt = r_fcnt + FC_ONE;
          end
        end
        default: begin
          w_nxt  = ST_IDLE;
          w_scnt = '0;
          w_fcnt = '0;
        end
      endcase
    end
  end

  // fabric is released only while lock is qualified (glitch window included)
  always_comb begin
    w_run = (w_nxt == ST_RUN) || (w_nxt == ST_FILTER);
  end

  // registered reset and lock status, updated on the transition edge
  always_ff @(posedge FAB_CLK) begin
    if (!M2F_RESET_N) begin
      r_rst_out <= 1'b0;
      r_locked  <= 1'b0;
    end else begin
      r_rst_out <= w_run;
      r_locked  <= w_run;
    end
  end

  // saturating loss counter; a clear coincident with a loss leaves one count
  always_ff @(posedge FAB_CLK) begin
    if (!M2F_RESET_N)             r_loss_cnt <= '0;
    else if (LOSS_CLR)            r_loss_cnt <= w_loss ? CNT_W'(1) : '0;
    else if (w_loss && !(&r_loss_cnt)) r_loss_cnt <= r_loss_cnt + CNT_W'(1);
  end

`ifdef CCC_LOCK_SUPERVISOR_IRQ_EN
  logic r_irq;

  // sticky loss interrupt; a new loss wins over a simultaneous clear
  always_ff @(posedge FAB_CLK) begin
    if (!M2F_RESET_N) r_irq <= 1'b0;
    else if (w_loss)  r_irq <= 1'b1;
    else if (IRQ_CLR) r_irq <= 1'b0;
  end

  assign IRQ = r_irq;
`endif

  assign FAB_RESET_N = r_rst_out;
  assign LOCKED      = r_locked;
  assign STATE       = r_state;
  assign LOSS_COUNT  = r_loss_cnt;

endmodule
